// File: rtl/ysyx_22050710_mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// funct3 op codes, FSM states and iteration-count constants.
package ysyx_22050710_mdu_pkg;

  localparam int MDU_XLEN   = 64;
  localparam int WORD_ITERS = MDU_XLEN / 2;
  localparam int CNT_W      = $clog2(MDU_XLEN);

  localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(MDU_XLEN - 1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORD_ITERS - 1);

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } mdu_state_e;

  function automatic logic [MDU_XLEN-1:0] ext_word(
    input logic [MDU_XLEN/2-1:0] w,
    input logic                  sgn
  );
    return {{(MDU_XLEN/2){sgn & w[MDU_XLEN/2-1]}}, w};
  endfunction

endpackage

// File: rtl/ysyx_22050710_div_iter.sv
// Restoring-divide step register: one quotient bit per i_step,
// operating on unsigned magnitudes loaded at i_load.
module ysyx_22050710_div_iter
  import ysyx_22050710_mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic            i_step,
  input  logic            i_word,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_last,
  output logic [XLEN-1:0] o_quot,
  output logic [XLEN-1:0] o_rem
);

  localparam int HW = XLEN / 2;

  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             word_q;

  logic [XLEN:0]    rem_sh;
  logic [XLEN:0]    diff;
  logic             ge;
  logic [XLEN-1:0]  rem_nx;
  logic [XLEN-1:0]  quo_nx;

  // rem_sh < 2*divisor, so the sign of diff is a valid compare
  always_comb begin
    rem_sh = {rem_q, quo_q[XLEN-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    ge     = ~diff[XLEN];
    rem_nx = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_nx = {quo_q[XLEN-2:0], ge};
  end

  assign o_last = cnt_q == (word_q ? LAST_WORD : LAST_FULL);
  assign o_quot = quo_nx;
  assign o_rem  = rem_nx;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      word_q <= 1'b0;
    end else if (i_load) begin
      rem_q  <= '0;
      quo_q  <= i_word ? {i_dividend[HW-1:0], {HW{1'b0}}}
                       : i_dividend;
      dvs_q  <= i_divisor;
      cnt_q  <= '0;
      word_q <= i_word;
    end else if (i_step) begin
      rem_q  <= rem_nx;
      quo_q  <= quo_nx;
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ysyx_22050710_mdu.sv
// Iterative RV64M multiply/divide unit: shift-add multiplier and
// restoring divider sequenced by a small FSM behind two handshakes.
module ysyx_22050710_mdu
  import ysyx_22050710_mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_op,
  input  logic            i_word,
  input  logic [XLEN-1:0] i_src1,
  input  logic [XLEN-1:0] i_src2,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);

  localparam int HW = XLEN / 2;

  mdu_state_e        state_q, state_d;
  mdu_op_e           op, op_q;
  logic              word_q, sgn_q, rneg_q;
  logic [2*XLEN-1:0] acc_q, acc_nx, prod;
  logic [XLEN-1:0]   mcd_q, res_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              accept, mlast, dlast, dload;

  logic              s1_sgn, s2_sgn, neg1, neg2;
  logic [XLEN-1:0]   ext1, ext2, mag1, mag2;
  logic              div_zero, div_ovf, fast;
  logic [XLEN-1:0]   fast_raw, fast_res;

  logic [XLEN:0]     msum;
  logic [HW-1:0]     wlow, wneg;
  logic [XLEN-1:0]   mul_res;

  logic [XLEN-1:0]   dquo, drem, qv, rv, draw, div_res;

  assign op       = mdu_op_e'(i_op);
  assign o_ready  = state_q == ST_IDLE;
  assign o_valid  = state_q == ST_DONE;
  assign o_busy   = ~o_ready;
  assign o_result = res_q;
  assign accept   = i_valid & o_ready & ~i_flush;

  always_comb begin
    s1_sgn = 1'b0;
    s2_sgn = 1'b0;
    unique case (1'b1)
      op == OP_MULHSU: s1_sgn = 1'b1;
      op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM}: begin
        s1_sgn = 1'b1;
        s2_sgn = 1'b1;
      end
      default: ;
    endcase
    ext1 = i_word ? ext_word(i_src1[HW-1:0], s1_sgn) : i_src1;
    ext2 = i_word ? ext_word(i_src2[HW-1:0], s2_sgn) : i_src2;
    neg1 = s1_sgn & ext1[XLEN-1];
    neg2 = s2_sgn & ext2[XLEN-1];
    mag1 = neg1 ? -ext1 : ext1;
    mag2 = neg2 ? -ext2 : ext2;
    div_zero = ext2 == '0;
    div_ovf  = s1_sgn & (ext2 == '1) &
               (ext1 == (i_word ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}}
                                : {1'b1, {(XLEN-1){1'b0}}}));
    fast = i_op[2] & (div_zero | div_ovf);
    if (div_zero) fast_raw = i_op[1] ? ext1 : '1;
    else          fast_raw = i_op[1] ? '0 : ext1;
    fast_res = i_word ? ext_word(fast_raw[HW-1:0], 1'b1) : fast_raw;
  end

  // After HW steps a word product sits at acc >> HW
  always_comb begin
    msum    = {1'b0, acc_q[2*XLEN-1:XLEN]}
            + (acc_q[0] ? {1'b0, mcd_q} : '0);
    acc_nx  = {msum, acc_q[XLEN-1:1]};
    prod    = sgn_q ? -acc_nx : acc_nx;
    wlow    = acc_nx[XLEN-1:HW];
    wneg    = sgn_q ? -wlow : wlow;
    mlast   = cnt_q == (word_q ? LAST_WORD : LAST_FULL);
    if (word_q)              mul_res = ext_word(wneg, 1'b1);
    else if (op_q == OP_MUL) mul_res = prod[XLEN-1:0];
    else                     mul_res = prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    qv      = sgn_q ? -dquo : dquo;
    rv      = rneg_q ? -drem : drem;
    draw    = op_q[1] ? rv : qv;
    div_res = word_q ? ext_word(draw[HW-1:0], 1'b1) : draw;
  end

  assign dload = accept & i_op[2] & ~fast;

  ysyx_22050710_div_iter #(.XLEN(XLEN)) u_div (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (dload),
    .i_step     (state_q == ST_DIV),
    .i_word     (i_word),
    .i_dividend (mag1),
    .i_divisor  (mag2),
    .o_last     (dlast),
    .o_quot     (dquo),
    .o_rem      (drem)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (i_valid)
                 state_d = fast    ? ST_DONE :
                           i_op[2] ? ST_DIV  : ST_MUL;
      ST_MUL:  if (mlast)   state_d = ST_DONE;
      ST_DIV:  if (dlast)   state_d = ST_DONE;
      ST_DONE: if (i_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (i_flush) state_d = ST_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op_q   <= OP_MUL;
      word_q <= 1'b0;
      sgn_q  <= 1'b0;
      rneg_q <= 1'b0;
      acc_q  <= '0;
      mcd_q  <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
    end else begin
      if (accept) begin
        op_q   <= op;
        word_q <= i_word;
        sgn_q  <= neg1 ^ neg2;
        rneg_q <= neg1;
        acc_q  <= {{XLEN{1'b0}}, mag1};
        mcd_q  <= mag2;
        cnt_q  <= '0;
        if (fast) res_q <= fast_res;
      end
      if (state_q == ST_MUL) begin
        acc_q <= acc_nx;
        cnt_q <= cnt_q + CNT_W'(1);
        if (mlast) res_q <= mul_res;
      end
      if (state_q == ST_DIV && dlast) res_q <= div_res;
    end
  end

endmodule

// File: tb/tb_ysyx_22050710_mdu.sv
// Bench for the iterative MDU: directed RV64M cases plus random ops
// checked against an arithmetic reference model.
module tb_ysyx_22050710_mdu;

  logic        i_clk = 1'b0;
  logic        i_rst, i_valid, i_word, i_flush, i_ready;
  logic [2:0]  i_op;
  logic [63:0] i_src1, i_src2;
  logic        o_ready, o_valid, o_busy;
  logic [63:0] o_result;

  int n_run  = 0;
  int n_fail = 0;

  ysyx_22050710_mdu dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_op     (i_op),
    .i_word   (i_word),
    .i_src1   (i_src1),
    .i_src2   (i_src2),
    .i_flush  (i_flush),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_busy   (o_busy)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [63:0] ref_result(
    input logic [2:0] op, input logic wd,
    input logic [63:0] a, input logic [63:0] b);
    logic [127:0]       xa, xb, p;
    logic [31:0]        a32, b32, r32;
    logic signed [31:0] sa32, sb32;
    logic signed [63:0] sa, sb;
    logic [63:0]        r;
    if (wd) begin
      a32 = a[31:0]; b32 = b[31:0];
      sa32 = a32;    sb32 = b32;
      r32 = '0;
      if (op < 4) r32 = a32 * b32;
      else if (b32 == 0) r32 = op[1] ? a32 : 32'hFFFF_FFFF;
      else if (!op[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF)
        r32 = op[1] ? 32'h0 : a32;
      else if (op == 4) r32 = sa32 / sb32;
      else if (op == 5) r32 = a32 / b32;
      else if (op == 6) r32 = sa32 % sb32;
      else              r32 = a32 % b32;
      return {{32{r32[31]}}, r32};
    end
    sa = a; sb = b;
    xa = (op == 1 || op == 2) ? {{64{a[63]}}, a} : {64'h0, a};
    xb = (op == 1)            ? {{64{b[63]}}, b} : {64'h0, b};
    p  = xa * xb;
    if (op == 0) r = p[63:0];
    else if (op < 4) r = p[127:64];
    else if (b == 0) r = op[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
    else if (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1)
      r = op[1] ? 64'h0 : a;
    else if (op == 4) r = sa / sb;
    else if (op == 5) r = a / b;
    else if (op == 6) r = sa % sb;
    else              r = a % b;
    return r;
  endfunction

  function automatic int ref_lat(
    input logic [2:0] op, input logic wd,
    input logic [63:0] a, input logic [63:0] b);
    logic zero, ovf;
    zero = wd ? b[31:0] == 0 : b == 0;
    ovf  = !op[0] && (wd ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1)
                         : (a == 64'h8000_0000_0000_0000 && b == '1));
    if (op[2] && (zero || ovf)) return 1;
    return wd ? 33 : 65;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0: return 64'h0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h0000_0000_8000_0000;
      4: return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Issues one op and waits (bounded) for o_valid; does not take it
  task automatic run_op(input logic [2:0] op, input logic wd,
                        input logic [63:0] a, input logic [63:0] b,
                        output int lat, output logic busy_ok);
    i_op = op; i_word = wd; i_src1 = a; i_src2 = b; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (!o_valid && lat < 200) begin
      if (o_ready !== 1'b0 || o_busy !== 1'b1) busy_ok = 1'b0;
      @(posedge i_clk); #1;
      lat++;
    end
    if (o_ready !== 1'b0 || o_busy !== 1'b1) busy_ok = 1'b0;
  endtask

  task automatic take();
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    int lat; logic bz;
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    n_run++;
    if ({o_ready, o_valid, o_busy} !== 3'b100 || o_result !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_state: rdy/vld/busy=%b result=%h want 100 / 0",
               {o_ready, o_valid, o_busy}, o_result);
    end
    run_op(3'd5, 1'b0, 64'd1000, 64'd3, lat, bz);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    n_run++;
    if ({o_ready, o_valid, o_busy} !== 3'b100 || o_result !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_in_done: rdy/vld/busy=%b result=%h want 100 / 0",
               {o_ready, o_valid, o_busy}, o_result);
    end
  endtask

  task automatic test_mul();
    logic [2:0]  ops [4] = '{3'd0, 3'd3, 3'd1, 3'd2};
    logic [63:0] as  [4] = '{64'd7, '1, '1, '1};
    logic [63:0] bs  [4] = '{64'hFFFF_FFFF_FFFF_FFFD, '1, '1, 64'd2};
    logic [63:0] ex  [4] = '{64'hFFFF_FFFF_FFFF_FFEB,
                             64'hFFFF_FFFF_FFFF_FFFE, 64'h0, '1};
    int lat; logic bz;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], 1'b0, as[i], bs[i], lat, bz);
      n_run++;
      if (o_result !== ex[i] || lat != 65 || bz !== 1'b1) begin
        n_fail++;
        $display("FAIL mul_%0d: result=%h lat=%0d busy_ok=%b want %h 65 1",
                 ops[i], o_result, lat, bz, ex[i]);
      end
      take();
    end
  endtask

  task automatic test_div_special();
    logic [2:0]  ops [8] = '{5, 7, 4, 4, 6, 4, 4, 6};
    logic        wds [8] = '{0, 0, 1, 0, 0, 1, 1, 1};
    logic [63:0] as  [8] = '{64'd123, 64'd123, 64'd5,
                             64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                             64'h8000_0000, 64'h0000_0001_FFFF_FFF9,
                             64'h0000_0001_FFFF_FFF9};
    logic [63:0] bs  [8] = '{0, 0, 0, '1, '1, '1, 64'd2, 64'd2};
    logic [63:0] ex  [8] = '{'1, 64'd123, '1, 64'h8000_0000_0000_0000, 0,
                             64'hFFFF_FFFF_8000_0000,
                             64'hFFFF_FFFF_FFFF_FFFD, '1};
    int          el  [8] = '{1, 1, 1, 1, 1, 1, 33, 33};
    int lat; logic bz;
    for (int i = 0; i < 8; i++) begin
      run_op(ops[i], wds[i], as[i], bs[i], lat, bz);
      n_run++;
      if (o_result !== ex[i] || lat != el[i]) begin
        n_fail++;
        $display("FAIL div_case%0d: result=%h lat=%0d want %h %0d",
                 i, o_result, lat, ex[i], el[i]);
      end
      take();
    end
    run_op(3'd5, 1'b1, 64'hFFFF_FFFE, 64'd1, lat, bz);
    n_run++;
    if (o_result !== 64'hFFFF_FFFF_FFFF_FFFE || lat != 33) begin
      n_fail++;
      $display("FAIL divuw: result=%h lat=%0d want fffffffffffffffe 33",
               o_result, lat);
    end
    take();
  endtask

  task automatic test_backpressure();
    int lat; logic bz; logic ok;
    run_op(3'd5, 1'b0, 64'd1000, 64'd9, lat, bz);
    n_run++;
    if (o_result !== 64'd111) begin
      n_fail++;
      $display("FAIL bp_result: got %h want %h", o_result, 64'd111);
    end
    ok = 1'b1;
    i_valid = 1'b1; i_op = 3'd0; i_src1 = 64'd3; i_src2 = 64'd3;
    repeat (5) begin
      @(posedge i_clk); #1;
      if (o_result !== 64'd111 || o_valid !== 1'b1 || o_ready !== 1'b0)
        ok = 1'b0;
    end
    i_valid = 1'b0;
    n_run++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_hold: result=%h vld=%b rdy=%b want 6f 1 0",
               o_result, o_valid, o_ready);
    end
    take();
    @(posedge i_clk); #1;
    n_run++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_after_take: rdy=%b vld=%b want 1 0", o_ready, o_valid);
    end
  endtask

  task automatic test_flush();
    int lat; logic bz; logic seen;
    i_op = 3'd4; i_word = 1'b0; i_src1 = 64'd987654321; i_src2 = 64'd3;
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (9) @(posedge i_clk);
    #1;
    i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    n_run++;
    if ({o_ready, o_valid, o_busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL flush_div: rdy/vld/busy=%b want 100",
               {o_ready, o_valid, o_busy});
    end
    seen = 1'b0;
    repeat (80) begin
      @(posedge i_clk); #1;
      if (o_valid) seen = 1'b1;
    end
    n_run++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_no_result: o_valid seen=%b want 0", seen);
    end
    i_op = 3'd0; i_src1 = 64'd9; i_src2 = 64'd9;
    i_valid = 1'b1; i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;
    n_run++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_vs_accept: rdy=%b busy=%b want 1 0",
               o_ready, o_busy);
    end
    run_op(3'd5, 1'b0, 64'd100, 64'd7, lat, bz);
    n_run++;
    if (o_result !== 64'd14 || lat != 65) begin
      n_fail++;
      $display("FAIL divu_after_flush: result=%h lat=%0d want e 65",
               o_result, lat);
    end
    take();
    run_op(3'd7, 1'b0, 64'd100, 64'd7, lat, bz);
    n_run++;
    if (o_result !== 64'd2 || lat != 65) begin
      n_fail++;
      $display("FAIL remu_after_flush: result=%h lat=%0d want 2 65",
               o_result, lat);
    end
    i_flush = 1'b1; i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0; i_ready = 1'b0;
    n_run++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_in_done: rdy=%b vld=%b want 1 0", o_ready, o_valid);
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic        wd;
    logic [63:0] a, b, exp_r;
    int lat, exp_l;
    logic bz;
    for (int i = 0; i < 80; i++) begin
      op = 3'($urandom_range(0, 7));
      wd = 1'($urandom_range(0, 1));
      a = pick();
      b = pick();
      exp_r = ref_result(op, wd, a, b);
      exp_l = ref_lat(op, wd, a, b);
      run_op(op, wd, a, b, lat, bz);
      n_run++;
      if (o_result !== exp_r || lat != exp_l) begin
        n_fail++;
        $display("FAIL rand%0d op=%0d w=%b a=%h b=%h: result=%h lat=%0d want %h %0d",
                 i, op, wd, a, b, o_result, lat, exp_r, exp_l);
      end
      repeat ($urandom_range(0, 2)) @(posedge i_clk);
      #1;
      take();
    end
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_word = 1'b0; i_flush = 1'b0;
    i_ready = 1'b0; i_op = 3'd0; i_src1 = '0; i_src2 = '0;
    @(posedge i_clk); #1;
    test_reset();
    test_mul();
    test_div_special();
    test_backpressure();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22050710_mdu.md
Name: ysyx_22050710_mdu

Overview:
Iterative multiply/divide unit that moves the RV64M operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and their W forms) out of the single-cycle execute datapath, where they are currently large combinational operators.
- The execute stage issues an operation through a valid/ready handshake, stalls while the unit is busy, and collects the result through a second valid/ready handshake.
- It contains a state machine that sequences a shift-add multiplier and a restoring divider, one bit per cycle.

Parameters:
XLEN, 64, operand/result width; word ops use XLEN/2

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_valid  in  1  issue request; operands and op are sampled when i_valid & o_ready
o_ready  out  1  unit can accept; high only in IDLE
i_op  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
i_word  in  1  W-form op (32-bit operands, 32-bit result sign-extended to 64)
i_src1  in  XLEN  rs1 / dividend
i_src2  in  XLEN  rs2 / divisor
i_flush  in  1  abandon the in-flight op (branch redirect / exception)
o_valid  out  1  o_result is valid
i_ready  in  1  consumer accepts the result when o_valid & i_ready
o_result  out  XLEN  result
o_busy  out  1  high in MUL, DIV or DONE (stall request)

Behaviour:
- Clock and reset: single clock i_clk. Reset i_rst is synchronous and active-high.
- Reset values: state=IDLE, o_ready=1, o_valid=0, o_busy=0, o_result=0. All internal registers are cleared.
- States:
  - IDLE -> MUL on accept with i_op<4.
  - IDLE -> DIV on accept with i_op>=4 and a normal divide.
  - IDLE -> DONE on accept of a special-case divide (fast path).
  - MUL/DIV -> DONE after N iterations; N = XLEN, or XLEN/2 when i_word.
  - DONE -> IDLE on o_valid & i_ready.
- Latency: accept at cycle 0 gives o_valid at cycle N+1. The fast path gives o_valid at cycle 1.
- Backpressure: in DONE, o_valid stays high and o_result stays stable until i_ready. No new op is accepted until the result is taken. The earliest next accept is the cycle after the handshake.
- Operand preparation at accept:
  - Word ops: operands are the low 32 bits, sign-extended for signed ops and zero-extended for unsigned ops.
  - Signed operands (per op) are converted to magnitude, and the result sign is latched.
  - MULHSU: src1 is signed, src2 is unsigned.
- MUL datapath: 2*XLEN-bit accumulator with shift-add, one multiplier bit per cycle. The accumulator is negated at the end if the latched sign is set.
  - MUL returns the low half.
  - MULH, MULHSU and MULHU return the high half.
- Word multiply: only MUL is defined (MULW). i_word with MULH, MULHSU or MULHU returns the MULW result; the decoder never issues it.
- DIV datapath: restoring divide, one quotient bit per cycle; partial remainder is XLEN+1 bits.
  - Quotient is negated when operand signs differ (signed ops).
  - Remainder takes the sign of the dividend.
- Fast path (no iteration):
  - Divisor == 0: quotient = all ones; remainder = dividend (as extended).
  - Signed overflow (dividend = most-negative, divisor = -1; width per i_word): quotient = dividend; remainder = 0.
- Word results: final [31:0] is sign-extended to XLEN, for both signed and unsigned W ops.
- Flush:
  - i_flush in any state forces IDLE next cycle and drops o_valid; no result is produced.
  - i_flush has priority over a same-cycle accept and over a same-cycle result handshake; that handshake is void.
  - Flush in IDLE is a no-op.
- Reset mid-operation: same effect as flush, plus register clear.
- i_valid while not o_ready is ignored; the issuer must hold it until accepted.

Decomposition:
- Shared package ysyx_22050710_mdu_pkg: MDU op codes (3-bit funct3 values above), state encoding (IDLE/MUL/DIV/DONE), and the localparam for the word-width iteration count.
- One natural sub-module: ysyx_22050710_div_iter, the restoring-divide step register (partial remainder, quotient shift, iteration counter). Multiply stays inline in the top-level FSM.

Test Plan:
1. MUL, src1=7, src2=0xFFFFFFFFFFFFFFFD -> o_valid at cycle 65, o_result=0xFFFFFFFFFFFFFFEB; o_ready=0 and o_busy=1 during cycles 1..65.
2. MULHU, both operands 0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFE. MULH with the same operands -> 0x0. MULHSU with src1=-1, src2=2 -> 0xFFFFFFFFFFFFFFFF.
3. Divide by zero: DIVU src1=123, src2=0 -> 0xFFFFFFFFFFFFFFFF at cycle 1. REMU with the same operands -> 123. DIVW src1=5, src2=0 -> 0xFFFFFFFFFFFFFFFF.
4. Signed overflow:
   - DIV src1=0x8000000000000000, src2=-1 -> 0x8000000000000000 at cycle 1; REM with the same operands -> 0.
   - DIVW src1=0x80000000, src2=-1 -> 0xFFFFFFFF80000000.
5. Word divide: DIV+i_word, src1=0x00000001FFFFFFF9 (low word = -7), src2=2 -> o_valid at cycle 33, result 0xFFFFFFFFFFFFFFFD. REMW with the same operands -> 0xFFFFFFFFFFFFFFFF. DIVUW src1=0xFFFFFFFE, src2=1 -> 0xFFFFFFFFFFFFFFFE.
6. Backpressure and flush:
   - Hold i_ready=0 for 5 cycles after o_valid: o_result stays stable and o_ready stays 0.
   - Issue a DIV, assert i_flush at iteration 10: o_valid never rises, o_ready=1 the next cycle.
   - A following DIVU 100/7 -> 14; REMU 100/7 -> 2.
